mcp01_controller: RTL
=====================

// Module: mcp01_controller
// PURPOSE
//  Multicycle control FSM for the MCP01 stack processor; drives every datapath control strobe.
//  Consumes opcode = IR[7:5] from the datapath and sequences fetch/decode/execute.
//  All control outputs are Moore outputs, decoded from the state register (plus the stable IR opcode).
//  ISA: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH a, 101 POP a, 110 JMP a, 111 JZ a (a = IR[4:0]).
// PARAMETERS
//  OPCODE_W  3  opcode width (fixed encoding above; other values unsupported)
//  STATE_W   4  state register width (15 states used)
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous, active-low reset
//  opcode       in   3  IR[7:5] from datapath, valid from DECODE until next FETCH
//  IorD         out  1  mem addr: 0=PC, 1=IR[4:0]
//  MemRead      out  1  memory read enable
//  MemWrite     out  1  memory write (data = stack d_out)
//  IR_Write     out  1  load IR
//  PC_Write     out  1  unconditional PC load
//  PCsel        out  1  PC source: 0=ALU result, 1=IR[4:0]
//  d_in_sel     out  1  stack push data: 0=MDR, 1=ALU_Out_Reg
//  push/pop/tos out  1  stack push / pop-to-d_out / copy-top-to-d_out (one-hot or all 0)
//  ldop1/ldop2  out  1  load op1/op2 from d_out
//  ALU_Src_A    out  1  0=PC, 1=op1
//  ALU_Src_B    out  1  0=const 1, 1=op2
//  ALU_Control  out  2  00 add, 01 sub, 10 and, 11 not(A)
//  JZ           out  1  conditional PC load when d_out==0
//  instr_done   out  1  high in final state of every instruction
//  state        out  4  current state (debug)
// BEHAVIOUR
//  Reset: rst low -> state=INIT immediately; every output 0 while in INIT. INIT -> FETCH on first clk with rst high.
//  Strobes not listed below are 0; ALU_Control=00 unless listed.
//  FETCH: IorD=0 MemRead=1 IR_Write=1 ALU_Src_A=0 ALU_Src_B=0 PC_Write=1 PCsel=0 (PC<=PC+1) -> DECODE.
//  DECODE: no strobes; branch on opcode: 0xx->POP1, 100->PSH_RD, 101->POP_M, 110->JMP, 111->JZ_TOS.
//  POP1: pop=1 -> LD1.
//  LD1: ldop1=1; pop=1 unless NOT; NOT->ALU else ->LD2.
//  LD2: ldop2=1 -> ALU.
//  ALU: ALU_Src_A=1 ALU_Src_B=1 ALU_Control=opcode[1:0] (result = op1 OP op2; op1 = old top) -> WB.
//  WB: push=1 d_in_sel=1 instr_done=1 -> FETCH.
//  PSH_RD: IorD=1 MemRead=1 (MDR latches) -> PSH_WB: push=1 d_in_sel=0 instr_done=1 -> FETCH.
//  POP_M: pop=1 -> POP_WR: IorD=1 MemWrite=1 instr_done=1 -> FETCH.
//  JMP: PCsel=1 PC_Write=1 instr_done=1 -> FETCH.
//  JZ_TOS: tos=1 (refresh d_out, non-destructive) -> JZ_EX: JZ=1 PCsel=1 instr_done=1 -> FETCH.
//  Cycles incl. FETCH: ADD/SUB/AND 7, NOT 6, PUSH 4, POP 4, JMP 3, JZ 4.
//  JZ not taken: PC keeps the FETCH increment. JZ never coincides with tos/pop (d_out stable).
//  Never assert push and pop (or tos) in the same cycle; never MemRead with MemWrite.
//  opcode X/unknown in DECODE -> FETCH, no side effects. opcode ignored outside DECODE/LD1/ALU.
//  Stack over/underflow not detected (datapath 5-bit top wraps).
//  rst asserted mid-instruction: abort at once to INIT, outputs 0, no partial strobe survives.
// TESTING
//  Reset: rst=0 for 3 clks, any opcode -> all outputs 0, state=INIT; release -> FETCH next edge.
//  Mem{PUSH 10, PUSH 11, ADD, POP 20}, M[10]=3, M[11]=4 -> M[20]=7, cycle count 4+4+7+4.
//  PUSH 5, PUSH 9, SUB (M[5]=2, M[9]=7) -> stack top 5 (7-2); NOT on 0x0F -> 0xF0 in 6 cycles.
//  JMP 0x1C -> PC=0x1C after 3 cycles; next FETCH address 0x1C.
//  JZ 0x08 with top=0 -> PC=0x08; with top=0x01 -> PC=old PC+1; stack depth unchanged.
//  Drop rst during ALU state of ADD -> outputs 0 same cycle; restart fetches from PC=0.

Source files
------------

// File: rtl/mcp01_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mcp01_controller: multicycle fetch/decode/execute control FSM for MCP01 CPU
// Rev 1.0
// ----------------------------------------------------------------------------
module mcp01_controller #(
  parameter int OPCODE_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IR_Write,
  output logic                PC_Write,
  output logic                PCsel,
  output logic                d_in_sel,
  output logic                push,
  output logic                pop,
  output logic                tos,
  output logic                ldop1,
  output logic                ldop2,
  output logic                ALU_Src_A,
  output logic                ALU_Src_B,
  output logic [1:0]          ALU_Control,
  output logic                JZ,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state
);

  typedef enum logic [STATE_W-1:0] {
    S_INIT, S_FETCH, S_DECODE, S_POP1, S_LD1, S_LD2, S_ALU, S_WB,
    S_PSH_RD, S_PSH_WB, S_POP_M, S_POP_WR, S_JMP, S_JZ_TOS, S_JZ_EX
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pcsel;
    logic       d_in_sel;
    logic       push;
    logic       pop;
    logic       tos;
    logic       ldop1;
    logic       ldop2;
    logic       src_a;
    logic       src_b;
    logic [1:0] alu_ctl;
    logic       jz;
    logic       done;
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_NOT = 3'b011;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          3'b000, 3'b001, 3'b010, 3'b011: state_d = S_POP1;
          3'b100:  state_d = S_PSH_RD;
          3'b101:  state_d = S_POP_M;
          3'b110:  state_d = S_JMP;
          3'b111:  state_d = S_JZ_TOS;
          default: state_d = S_FETCH;  // unknown opcode: refetch without side effects
        endcase
      end
      S_POP1:   state_d = S_LD1;
      S_LD1:    state_d = (opcode == OP_NOT) ? S_ALU : S_LD2;
      S_LD2:    state_d = S_ALU;
      S_ALU:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_PSH_RD: state_d = S_PSH_WB;
      S_PSH_WB: state_d = S_FETCH;
      S_POP_M:  state_d = S_POP_WR;
      S_POP_WR: state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_JZ_TOS: state_d = S_JZ_EX;
      S_JZ_EX:  state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  // Strobes are decoded from the upcoming state so they register alongside it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      S_POP1:   ctrl_d.pop = 1'b1;
      S_LD1: begin
        ctrl_d.ldop1 = 1'b1;
        ctrl_d.pop   = (opcode != OP_NOT);
      end
      S_LD2:    ctrl_d.ldop2 = 1'b1;
      S_ALU: begin
        ctrl_d.src_a   = 1'b1;
        ctrl_d.src_b   = 1'b1;
        ctrl_d.alu_ctl = opcode[1:0];
      end
      S_WB: begin
        ctrl_d.push     = 1'b1;
        ctrl_d.d_in_sel = 1'b1;
        ctrl_d.done     = 1'b1;
      end
      S_PSH_RD: begin
        ctrl_d.iord     = 1'b1;
        ctrl_d.mem_read = 1'b1;
      end
      S_PSH_WB: begin
        ctrl_d.push = 1'b1;
        ctrl_d.done = 1'b1;
      end
      S_POP_M:  ctrl_d.pop = 1'b1;
      S_POP_WR: begin
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      S_JMP: begin
        ctrl_d.pcsel    = 1'b1;
        ctrl_d.pc_write = 1'b1;
        ctrl_d.done     = 1'b1;
      end
      S_JZ_TOS: ctrl_d.tos = 1'b1;
      S_JZ_EX: begin
        ctrl_d.jz    = 1'b1;
        ctrl_d.pcsel = 1'b1;
        ctrl_d.done  = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign IR_Write    = ctrl_q.ir_write;
  assign PC_Write    = ctrl_q.pc_write;
  assign PCsel       = ctrl_q.pcsel;
  assign d_in_sel    = ctrl_q.d_in_sel;
  assign push        = ctrl_q.push;
  assign pop         = ctrl_q.pop;
  assign tos         = ctrl_q.tos;
  assign ldop1       = ctrl_q.ldop1;
  assign ldop2       = ctrl_q.ldop2;
  assign ALU_Src_A   = ctrl_q.src_a;
  assign ALU_Src_B   = ctrl_q.src_b;
  assign ALU_Control = ctrl_q.alu_ctl;
  assign JZ          = ctrl_q.jz;
  assign instr_done  = ctrl_q.done;
  assign state       = state_q;

endmodule
`default_nettype wire
